mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-addressed CPU load/store front end for a lane-organised RAM.
// Lane-crossing accesses are split into two beats (or rejected), and load results are sign/zero extended.
module mem_access_unit #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [1:0]              cpu_size,
    input  logic                    cpu_store,
    input  logic                    cpu_unsigned,
    output logic                    cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_err,
    output logic                    ram_valid,
    input  logic                    ram_ready,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_byteSelect,
    output logic                    ram_store,
    input  logic                    ram_rvalid,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int B  = DATA_WIDTH / 8;
    localparam int LB = $clog2(B);
    localparam int W2 = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    armed_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]              size_q;
    logic                    store_q;
    logic                    uns_q;
    logic                    split_q;
    logic [DATA_WIDTH-1:0]   rd0_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic                    accept;
    logic                    acc_err;
    logic [LB-1:0]           off_q;
    int                      n_q;
    logic [DATA_WIDTH-1:0]   wdata_trim;
    logic [W2-1:0]           wide_w;
    logic [2*B-1:0]          wide_mask;
    logic                    beat1;
    logic [ADDR_WIDTH-1:0]   beat_base;
    logic [DATA_WIDTH-1:0]   load_result;

    function automatic int lane_count(input logic [1:0] size);
        if (int'(size) > LB) return B;
        return 1 << size;
    endfunction

    function automatic logic is_split(input logic [LB-1:0] off, input logic [1:0] size);
        logic [LB+1:0] end_pos;
        end_pos = {2'b00, off} + ((LB+2)'(1) << size);
        return end_pos > (LB+2)'(B);
    endfunction

    // Shift the two beats down so the access starts at byte 0, then extend above n bytes.
    function automatic logic [DATA_WIDTH-1:0] assemble_load(
        input logic [DATA_WIDTH-1:0] beat0,
        input logic [DATA_WIDTH-1:0] beat1_data,
        input logic [LB-1:0]         off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [W2-1:0]         wide;
        logic [DATA_WIDTH-1:0] raw;
        logic [DATA_WIDTH-1:0] res;
        logic                  sign;
        int                    n;
        n    = lane_count(size);
        wide = {beat1_data, beat0} >> {off, 3'b000};
        raw  = wide[DATA_WIDTH-1:0];
        sign = raw[8*n-1] & ~uns;
        res  = '0;
        for (int i = 0; i < B; i++)
            res[i*8 +: 8] = (i < n) ? raw[i*8 +: 8] : {8{sign}};
        return res;
    endfunction

    assign accept  = cpu_valid && cpu_ready;
    assign acc_err = (int'(cpu_size) > LB) ||
                     ((ALLOW_MISALIGNED == 0) && is_split(cpu_addr[LB-1:0], cpu_size));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = acc_err ? RESP : REQ0;
            REQ0:  if (ram_ready) state_nxt = store_q ? (split_q ? REQ1 : RESP) : WAIT0;
            WAIT0: if (ram_rvalid) state_nxt = split_q ? REQ1 : RESP;
            REQ1:  if (ram_ready) state_nxt = store_q ? RESP : WAIT1;
            WAIT1: if (ram_rvalid) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign off_q = addr_q[LB-1:0];
    assign n_q   = lane_count(size_q);
    assign beat1 = (state == REQ1);

    always_comb begin
        wdata_trim = '0;
        for (int i = 0; i < B; i++)
            if (i < n_q) wdata_trim[i*8 +: 8] = wdata_q[i*8 +: 8];
    end

    // Double-width views: low half belongs to beat 0, high half to beat 1.
    assign wide_w    = W2'(wdata_trim) << {off_q, 3'b000};
    assign wide_mask = (2*B)'((64'd1 << n_q) - 64'd1) << off_q;
    assign beat_base = {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}};

    assign cpu_ready      = (state == IDLE) && armed_q;
    assign cpu_rsp_valid  = (state == RESP);
    assign cpu_rdata      = rdata_q;
    assign cpu_err        = err_q;
    assign ram_valid      = (state == REQ0) || (state == REQ1);
    assign ram_store      = ram_valid && store_q;
    assign ram_addr       = !ram_valid ? '0 : (beat1 ? beat_base + ADDR_WIDTH'(B) : beat_base);
    assign ram_byteSelect = !ram_valid ? '0 : (beat1 ? wide_mask[2*B-1:B] : wide_mask[B-1:0]);
    assign ram_wdata      = !ram_store ? '0 :
                            (beat1 ? wide_w[W2-1:DATA_WIDTH] : wide_w[DATA_WIDTH-1:0]);

    assign load_result = assemble_load((state == WAIT1) ? rd0_q : ram_rdata, ram_rdata,
                                       off_q, size_q, uns_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            armed_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            rd0_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed_q <= 1'b1;
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                size_q  <= cpu_size;
                store_q <= cpu_store;
                uns_q   <= cpu_unsigned;
                split_q <= is_split(cpu_addr[LB-1:0], cpu_size);
            end
            if (state == WAIT0 && ram_rvalid)
                rd0_q <= ram_rdata;
            // Response fields update only on entry to RESP and hold until the next one.
            if (state_nxt == RESP) begin
                if (state == IDLE) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (store_q) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= load_result;
                    err_q   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit lanes): one unit splitting misaligned accesses,
// one rejecting them; all expected values are hand-computed.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_valid_b;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_store, cpu_unsigned;
    logic        ram_ready, ram_rvalid;
    logic [31:0] ram_rdata;

    logic        cpu_ready, cpu_rsp_valid, cpu_err, ram_valid, ram_store;
    logic [31:0] cpu_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_byteSelect;

    logic        cpu_ready_b, cpu_rsp_valid_b, cpu_err_b, ram_valid_b, ram_store_b;
    logic [31:0] cpu_rdata_b, ram_addr_b, ram_wdata_b;
    logic [3:0]  ram_byteSelect_b;

    int n_vec = 0;
    int n_bad = 0;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_store(cpu_store),
        .cpu_unsigned(cpu_unsigned), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_byteSelect(ram_byteSelect), .ram_store(ram_store),
        .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
    );

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(0)) dut_na (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid_b), .cpu_ready(cpu_ready_b), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_store(cpu_store),
        .cpu_unsigned(cpu_unsigned), .cpu_rsp_valid(cpu_rsp_valid_b),
        .cpu_rdata(cpu_rdata_b), .cpu_err(cpu_err_b),
        .ram_valid(ram_valid_b), .ram_ready(ram_ready), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_byteSelect(ram_byteSelect_b), .ram_store(ram_store_b),
        .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, let it be accepted, then scramble the request fields.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input logic st, input logic un);
        check("ready_idle", cpu_ready, 1);
        cpu_addr = a; cpu_wdata = wd; cpu_size = sz; cpu_store = st; cpu_unsigned = un;
        cpu_valid = 1'b1;
        tick();
        cpu_valid = 1'b0;
        cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0BAD_0BAD; cpu_size = 2'd0;
        cpu_store = ~st; cpu_unsigned = ~un;
        check("ready_busy", cpu_ready, 0);
    endtask

    task automatic store_seq(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz, input logic two,
                             input logic [31:0] a0, input logic [3:0] bs0, input logic [31:0] w0,
                             input logic [31:0] a1, input logic [3:0] bs1, input logic [31:0] w1);
        issue(a, wd, sz, 1'b1, 1'b0);
        check({tag, "_valid0"}, ram_valid, 1);
        check({tag, "_addr0"}, ram_addr, a0);
        check({tag, "_bs0"}, ram_byteSelect, bs0);
        check({tag, "_wdata0"}, ram_wdata, w0);
        check({tag, "_store0"}, ram_store, 1);
        tick();
        check({tag, "_stall_valid"}, ram_valid, 1);
        check({tag, "_stall_addr"}, ram_addr, a0);
        check({tag, "_stall_wdata"}, ram_wdata, w0);
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
        if (two) begin
            check({tag, "_valid1"}, ram_valid, 1);
            check({tag, "_addr1"}, ram_addr, a1);
            check({tag, "_bs1"}, ram_byteSelect, bs1);
            check({tag, "_wdata1"}, ram_wdata, w1);
            ram_ready = 1'b1;
            tick();
            ram_ready = 1'b0;
        end
        check({tag, "_rsp"}, cpu_rsp_valid, 1);
        check({tag, "_err"}, cpu_err, 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_valid_drop"}, ram_valid, 0);
        tick();
        check({tag, "_rsp_once"}, cpu_rsp_valid, 0);
    endtask

    task automatic load_seq(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic un, input logic two,
                            input logic [31:0] a0, input logic [3:0] bs0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [3:0] bs1, input logic [31:0] d1,
                            input logic [31:0] exp);
        issue(a, 32'hCAFE_F00D, sz, 1'b0, un);
        check({tag, "_valid0"}, ram_valid, 1);
        check({tag, "_addr0"}, ram_addr, a0);
        check({tag, "_bs0"}, ram_byteSelect, bs0);
        check({tag, "_store0"}, ram_store, 0);
        // Stray read data while requesting must be ignored.
        ram_ready = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'h5A5A_5A5A;
        tick();
        ram_ready = 1'b0;
        check({tag, "_wait0"}, ram_valid, 0);
        ram_rvalid = 1'b1; ram_rdata = d0;
        tick();
        ram_rvalid = 1'b0; ram_rdata = 32'hDEAD_DEAD;
        if (two) begin
            check({tag, "_valid1"}, ram_valid, 1);
            check({tag, "_addr1"}, ram_addr, a1);
            check({tag, "_bs1"}, ram_byteSelect, bs1);
            ram_ready = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'hA5A5_A5A5;
            tick();
            ram_ready = 1'b0;
            ram_rvalid = 1'b1; ram_rdata = d1;
            tick();
            ram_rvalid = 1'b0; ram_rdata = 32'hDEAD_DEAD;
        end
        check({tag, "_rsp"}, cpu_rsp_valid, 1);
        check({tag, "_rdata"}, cpu_rdata, exp);
        check({tag, "_err"}, cpu_err, 0);
        tick();
        check({tag, "_rsp_once"}, cpu_rsp_valid, 0);
        check({tag, "_rdata_hold"}, cpu_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        cpu_valid = 1'b0; cpu_valid_b = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_size = '0; cpu_store = 1'b0; cpu_unsigned = 1'b0;
        ram_ready = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;

        #1;
        check("rst_ready", cpu_ready, 0);
        check("rst_ram_valid", ram_valid, 0);
        check("rst_rsp", cpu_rsp_valid, 0);
        check("rst_bs", ram_byteSelect, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_err", cpu_err, 0);
        tick();
        tick();
        check("rst_ready_clocked", cpu_ready, 0);
        reset = 1'b1;
        tick();
        check("ready_after_rst", cpu_ready, 1);

        store_seq("st_word", 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0,
                  32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'b0000, 32'h0);

        load_seq("ld_byte_s", 32'h103, 2'd0, 1'b0, 1'b0,
                 32'h100, 4'b1000, 32'h8000_0000, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        load_seq("ld_byte_u", 32'h103, 2'd0, 1'b1, 1'b0,
                 32'h100, 4'b1000, 32'h8000_0000, 32'h0, 4'b0000, 32'h0, 32'h0000_0080);
        load_seq("ld_half_split", 32'h103, 2'd1, 1'b0, 1'b1,
                 32'h100, 4'b1000, 32'hAB00_0000, 32'h104, 4'b0001, 32'h0000_00CD, 32'hFFFF_CDAB);
        load_seq("ld_word_wrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 1'b1,
                 32'hFFFF_FFFC, 4'b1100, 32'hDDCC_0000, 32'h0, 4'b0011, 32'h0000_BBAA, 32'hBBAA_DDCC);

        // Double-word on a 32-bit bus is rejected without touching the RAM.
        issue(32'h200, 32'h1234_5678, 2'd3, 1'b0, 1'b0);
        check("err_size_rsp", cpu_rsp_valid, 1);
        check("err_size_err", cpu_err, 1);
        check("err_size_rdata", cpu_rdata, 0);
        check("err_size_noram", ram_valid, 0);
        tick();
        check("err_size_rsp_once", cpu_rsp_valid, 0);
        check("err_size_hold", cpu_err, 1);
        check("err_size_noram2", ram_valid, 0);

        store_seq("st_word_split", 32'h102, 32'h1122_3344, 2'd2, 1'b1,
                  32'h100, 4'b1100, 32'h3344_0000, 32'h104, 4'b0011, 32'h0000_1122);
        store_seq("st_half", 32'h101, 32'hFFFF_A55A, 2'd1, 1'b0,
                  32'h100, 4'b0110, 32'h00A5_5A00, 32'h0, 4'b0000, 32'h0);
        load_seq("ld_half_u", 32'h206, 2'd1, 1'b1, 1'b0,
                 32'h204, 4'b1100, 32'h9ABC_1234, 32'h0, 4'b0000, 32'h0, 32'h0000_9ABC);

        // The non-splitting unit rejects the lane-crossing word store.
        check("na_ready", cpu_ready_b, 1);
        cpu_addr = 32'h102; cpu_wdata = 32'h1122_3344; cpu_size = 2'd2;
        cpu_store = 1'b1; cpu_unsigned = 1'b0; cpu_valid_b = 1'b1;
        tick();
        cpu_valid_b = 1'b0;
        check("na_rsp", cpu_rsp_valid_b, 1);
        check("na_err", cpu_err_b, 1);
        check("na_rdata", cpu_rdata_b, 0);
        check("na_noram", ram_valid_b, 0);
        tick();
        check("na_rsp_once", cpu_rsp_valid_b, 0);
        check("na_noram2", ram_valid_b, 0);

        // Reset while a beat is outstanding: ram_valid must fall without a clock edge.
        issue(32'h300, 32'h0, 2'd2, 1'b0, 1'b0);
        check("rstA_valid", ram_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("rstA_valid_drop", ram_valid, 0);
        check("rstA_ready", cpu_ready, 0);
        check("rstA_rdata_clr", cpu_rdata, 0);
        #2 reset = 1'b1;
        tick();
        check("rstA_ready_back", cpu_ready, 1);
        check("rstA_norsp", cpu_rsp_valid, 0);

        // Reset in WAIT0 with read data stalled, then a fresh aligned load.
        issue(32'h400, 32'h0, 2'd2, 1'b0, 1'b0);
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
        tick();
        check("rstB_wait_norsp", cpu_rsp_valid, 0);
        #2 reset = 1'b0;
        #1;
        check("rstB_valid", ram_valid, 0);
        check("rstB_rsp", cpu_rsp_valid, 0);
        check("rstB_ready", cpu_ready, 0);
        tick();
        check("rstB_ready_clocked", cpu_ready, 0);
        reset = 1'b1;
        ram_rvalid = 1'b1; ram_rdata = 32'h7777_7777;
        tick();
        ram_rvalid = 1'b0;
        check("rstB_ready_back", cpu_ready, 1);
        check("rstB_norsp", cpu_rsp_valid, 0);
        tick();
        check("rstB_norsp2", cpu_rsp_valid, 0);
        load_seq("ld_after_rst", 32'h200, 2'd2, 1'b0, 1'b0,
                 32'h200, 4'b1111, 32'h1234_5678, 32'h0, 4'b0000, 32'h0, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
